mpp_fetch_unit: RTL and testbench
=================================

// Module: mpp_fetch_unit
// PURPOSE
//  Instruction fetch controller between the mpp core and external byte-wide program memory.
//  Sequences program-memory reads and generates program_addr plus an active-low chip select per byte.
//  Buffers fetched bytes in a small prefetch FIFO and hands them to the core over a valid/ready handshake.
//  Supports jumps, which flush the FIFO, and back-pressure from the core.
// PARAMETERS
//  ADDR_W       16      program address width
//  DATA_W       8       instruction byte width
//  DEPTH        4       prefetch FIFO entries (power of 2, >=2)
//  WAIT_STATES  1       extra cycles chip select is held low before data is sampled (0..15)
//  RESET_PC     16'h0   first fetch address after reset
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  fetch_en      in   1       1 = start new fetches when the FIFO has room
//  jump          in   1       1-cycle pulse: redirect fetch to jump_addr
//  jump_addr     in   ADDR_W  jump target
//  instr         out  DATA_W  head-of-FIFO instruction byte
//  instr_addr    out  ADDR_W  address of instr
//  instr_valid   out  1       instr/instr_addr are valid
//  instr_ready   in   1       core accepts instr this cycle
//  program_addr  out  ADDR_W  address to program memory, registered
//  program_cs_n  out  1       program memory chip select, active low, registered
//  program_data  in   DATA_W  program memory read data
// BEHAVIOUR
//  Reset (async, immediate): program_cs_n=1, program_addr=RESET_PC, fetch_pc=RESET_PC,
//   FIFO empty, instr_valid=0, instr=0, instr_addr=0, state=IDLE, wait_cnt=0.
//  FSM (registered outputs):
//   IDLE: cs_n=1. If fetch_en && count<DEPTH && !jump: go to REQ; cs_n<=0; program_addr<=fetch_pc;
//     wait_cnt<=WAIT_STATES.
//   REQ: cs_n=0. If wait_cnt!=0: decrement. If wait_cnt==0: sample program_data; push {fetch_pc,data};
//     fetch_pc<=fetch_pc+1; cs_n<=1; go to GAP.
//   GAP: cs_n=1 for exactly one cycle, then go to IDLE (same rules), so every byte gets its own cs_n falling edge.
//  Cost per byte: cs_n is low for WAIT_STATES+1 cycles and high for at least 1 cycle.
//  Only one fetch is in flight. REQ starts only when count<DEPTH, so a push never overflows the FIFO.
//  fetch_pc is modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000.
//  fetch_en deasserted during REQ: the current byte completes and is pushed; no new REQ starts.
//  Handshake: a pop occurs when instr_valid && instr_ready. instr_valid = (count!=0).
//   instr/instr_addr show the FIFO head and stay stable while valid && !ready.
//   Push and pop in the same cycle: count is unchanged. A pop never occurs when empty.
//  Jump (highest priority):
//   - FIFO is flushed (instr_valid=0 in the next cycle) and fetch_pc<=jump_addr.
//   - A pop in the same cycle is ignored.
//   - In REQ: the fetch is aborted, no push, cs_n<=1, go to GAP.
//   - In IDLE/GAP: go to or stay in GAP, then fetch from jump_addr.
//   - The first byte after a jump is always from jump_addr.
//  Reset mid-operation: cs_n goes high asynchronously; any partial fetch is discarded; fetch restarts at RESET_PC.
// TESTING
//  ROM model (addr->data): 0000:07 0001:C0 0002:44 0003:C1 0004:CB 000F:07 0010:03 FFFF:AA, else 00. WAIT_STATES=1.
//  T1 stream: reset, fetch_en=1, instr_ready=1 -> core receives (0000,07),(0001,C0),(0002,44),(0003,C1),(0004,CB).
//     cs_n low 2 cycles / high 1 cycle per byte.
//  T2 backpressure: instr_ready=0 -> 4 bytes (07,C0,44,C1) buffered; cs_n stays 1; instr=07 held stable.
//     Then ready=1 -> pops in order; next fetch is address 0004 (CB).
//  T3 jump in REQ: pulse jump, jump_addr=000F, while cs_n=0 -> cs_n=1 next cycle; instr_valid=0 next cycle.
//     Next delivered bytes are (000F,07),(0010,03); no stale byte appears.
//  T4 wrap: jump to FFFF -> delivers (FFFF,AA), then (0000,07).
//  T5 async reset: assert rst_n=0 mid-REQ with no clock edge -> cs_n=1 and instr_valid=0 immediately.
//     After release, the first fetch is at 0000.
//  T6 fetch_en=0 during REQ -> the current byte is delivered; cs_n stays 1 afterwards; FIFO count is stable.

Source files
------------

// File: rtl/mpp_fetch_if.sv
// Fetch-unit bus: core handshake, jump request and byte-wide program-memory port.
interface mpp_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              fetch_en;
    logic              jump;
    logic [ADDR_W-1:0] jump_addr;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] program_addr;
    logic              program_cs_n;
    logic [DATA_W-1:0] program_data;

    // Core plus program memory side.
    modport master (
        output fetch_en, jump, jump_addr, instr_ready, program_data,
        input  instr, instr_addr, instr_valid, program_addr, program_cs_n
    );

    // Fetch unit side.
    modport slave (
        input  fetch_en, jump, jump_addr, instr_ready, program_data,
        output instr, instr_addr, instr_valid, program_addr, program_cs_n
    );
endinterface

// File: rtl/mpp_fetch_unit.sv
// Instruction fetch controller: one byte read in flight at a time, prefetch FIFO
// towards the core, jump redirect with FIFO flush.
module mpp_fetch_unit #(
    parameter int              ADDR_W      = 16,
    parameter int              DATA_W      = 8,
    parameter int              DEPTH       = 4,
    parameter int              WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    mpp_fetch_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              cs_n_q, cs_n_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        wait_q, wait_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic push, pop, can_start, valid;

    assign valid     = (count_q != '0);
    // A jump cancels both the byte being read and any pop in the same cycle.
    assign push      = (state_q == S_REQ) && (wait_q == 4'd0) && !bus.jump;
    assign pop       = valid && bus.instr_ready && !bus.jump;
    // Room is judged on the registered count, so an in-flight byte always fits.
    assign can_start = bus.fetch_en && (count_q < CW'(DEPTH)) && !bus.jump;

    // Fetch sequencer: IDLE/GAP start a request, REQ waits then samples the byte.
    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        paddr_d = paddr_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                if (bus.jump) begin
                    state_d = S_GAP;
                    pc_d    = bus.jump_addr;
                end else if (can_start) begin
                    state_d = S_REQ;
                    cs_n_d  = 1'b0;
                    paddr_d = pc_q;
                    wait_d  = 4'(WAIT_STATES);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.jump) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    pc_d    = bus.jump_addr;
                end else if (wait_q != 4'd0) begin
                    wait_d  = wait_q - 4'd1;
                end else begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // FIFO pointer and occupancy update; a jump empties the queue.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (bus.jump) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // Control state with asynchronous reset so chip select drops off immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cs_n_q  <= 1'b1;
            paddr_q <= RESET_PC;
            pc_q    <= RESET_PC;
            wait_q  <= 4'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            paddr_q <= paddr_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage, written with the fetched byte and the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wptr_q] <= pc_q;
            mem_data_q[wptr_q] <= bus.program_data;
        end
    end

    // Head is masked to zero while empty so reset and flush present clean outputs.
    assign bus.instr_valid  = valid;
    assign bus.instr        = valid ? mem_data_q[rptr_q] : '0;
    assign bus.instr_addr   = valid ? mem_addr_q[rptr_q] : '0;
    assign bus.program_addr = paddr_q;
    assign bus.program_cs_n = cs_n_q;
endmodule

// File: tb/tb_mpp_fetch_unit.sv
// Bench for mpp_fetch_unit: ROM model on the memory port, scoreboard of expected
// (addr, byte) pairs on the core side, table of jump scenarios plus corner sequences.
module tb_mpp_fetch_unit;
    logic clk;
    logic rst_n;

    mpp_fetch_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    mpp_fetch_unit #(
        .ADDR_W(16), .DATA_W(8), .DEPTH(4), .WAIT_STATES(1), .RESET_PC(16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h07;
            16'h0001: return 8'hC0;
            16'h0002: return 8'h44;
            16'h0003: return 8'hC1;
            16'h0004: return 8'hCB;
            16'h000F: return 8'h07;
            16'h0010: return 8'h03;
            16'hFFFF: return 8'hAA;
            default:  return 8'h00;
        endcase
    endfunction

    assign bus.program_data = rom(bus.program_addr);

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } item_t;

    typedef struct {
        int          pre;
        logic [15:0] jaddr;
        logic [7:0]  d0;
        logic [15:0] a1;
        logic [7:0]  d1;
    } jvec_t;

    item_t q[$];
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        item_t it;
        it.a = a;
        it.d = d;
        q.push_back(it);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.fetch_en    = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_addr   = 16'h0;
        bus.instr_ready = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; samples pops until n items are seen, optionally timing cs_n runs.
    task automatic collect(input int n, input bit chk_cs, input string nm);
        int    got = 0;
        int    cyc = 0;
        int    lo = 0;
        int    hi = 0;
        bit    prev = 1'b1;
        bit    seen = 1'b0;
        item_t e;
        forever begin
            if (chk_cs) begin
                if (bus.program_cs_n == 1'b0) begin
                    if (prev) begin
                        if (seen) chk({nm, "_cs_high_len"}, hi, 1);
                        seen = 1'b1;
                        lo   = 0;
                    end
                    lo++;
                end else begin
                    if (!prev) begin
                        chk({nm, "_cs_low_len"}, lo, 2);
                        hi = 0;
                    end
                    hi++;
                end
                prev = bus.program_cs_n;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (q.size() == 0) begin
                    chk({nm, "_unexpected_pop_addr"}, bus.instr_addr, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk({nm, "_addr"}, bus.instr_addr, e.a);
                    chk({nm, "_data"}, bus.instr, e.d);
                end
                got++;
            end
            if (got >= n || cyc >= 60 * n + 20) break;
            @(negedge clk);
            cyc++;
        end
        if (got < n) begin
            chk({nm, "_timeout_items"}, got, n);
            q.delete();
        end
    endtask

    task automatic wait_cs_low(input bit need_valid, input string nm);
        int c = 0;
        while (!(bus.program_cs_n == 1'b0 && (!need_valid || bus.instr_valid)) && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_wait_req"}, (c < 60), 1);
    endtask

    jvec_t jt[4];
    logic [7:0] stream [5];

    initial begin
        jt[0] = '{pre: 0, jaddr: 16'h000F, d0: 8'h07, a1: 16'h0010, d1: 8'h03};
        jt[1] = '{pre: 2, jaddr: 16'hFFFF, d0: 8'hAA, a1: 16'h0000, d1: 8'h07};
        jt[2] = '{pre: 1, jaddr: 16'h0002, d0: 8'h44, a1: 16'h0003, d1: 8'hC1};
        jt[3] = '{pre: 3, jaddr: 16'h0003, d0: 8'hC1, a1: 16'h0004, d1: 8'hCB};
        stream[0] = 8'h07; stream[1] = 8'hC0; stream[2] = 8'h44;
        stream[3] = 8'hC1; stream[4] = 8'hCB;

        rst_n           = 1'b0;
        bus.fetch_en    = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_addr   = 16'h0;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_cs_n",       bus.program_cs_n, 1);
        chk("rst_valid",      bus.instr_valid,  0);
        chk("rst_instr",      bus.instr,        0);
        chk("rst_instr_addr", bus.instr_addr,   0);
        chk("rst_prog_addr",  bus.program_addr, 0);

        // T1 stream
        do_reset();
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_exp(16'(i), stream[i]);
        collect(5, 1'b1, "t1");

        // T2 back-pressure
        do_reset();
        bus.fetch_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                chk("t2_hold_instr", bus.instr, 8'h07);
                chk("t2_hold_addr",  bus.instr_addr, 16'h0000);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_full_cs_n", bus.program_cs_n, 1);
        end
        chk("t2_valid", bus.instr_valid, 1);
        for (int i = 0; i < 5; i++) push_exp(16'(i), stream[i]);
        bus.instr_ready = 1'b1;
        collect(5, 1'b0, "t2");

        // T3/T4 jumps issued while a request is in flight
        for (int k = 0; k < 4; k++) begin
            do_reset();
            bus.fetch_en    = 1'b1;
            bus.instr_ready = 1'b1;
            for (int i = 0; i < jt[k].pre; i++) push_exp(16'(i), stream[i]);
            if (jt[k].pre > 0) collect(jt[k].pre, 1'b0, "jpre");
            wait_cs_low(1'b0, "jump");
            bus.jump      = 1'b1;
            bus.jump_addr = jt[k].jaddr;
            @(negedge clk);
            bus.jump = 1'b0;
            chk("jump_cs_n",  bus.program_cs_n, 1);
            chk("jump_valid", bus.instr_valid,  0);
            push_exp(jt[k].jaddr, jt[k].d0);
            push_exp(jt[k].a1,    jt[k].d1);
            collect(2, 1'b0, "jump");
        end

        // T5 asynchronous reset during a request
        do_reset();
        bus.fetch_en = 1'b1;
        wait_cs_low(1'b1, "t5");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cs_n",  bus.program_cs_n, 1);
        chk("t5_valid", bus.instr_valid,  0);
        chk("t5_instr", bus.instr,        0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_prog_addr", bus.program_addr, 0);
        bus.instr_ready = 1'b1;
        push_exp(16'h0000, 8'h07);
        push_exp(16'h0001, 8'hC0);
        collect(2, 1'b0, "t5");

        // T6 fetch_en dropped mid-request
        do_reset();
        bus.fetch_en = 1'b1;
        wait_cs_low(1'b0, "t6");
        bus.fetch_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("t6_cs_n",  bus.program_cs_n, 1);
            chk("t6_valid", bus.instr_valid,  1);
            chk("t6_instr", bus.instr,        8'h07);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        push_exp(16'h0000, 8'h07);
        collect(1, 1'b0, "t6");
        repeat (4) @(negedge clk);
        chk("t6_empty_after", bus.instr_valid,  0);
        chk("t6_idle_cs_n",   bus.program_cs_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
